rand_range: RTL and testbench

RAND_RANGE -- requirements
Module: rand_range

---
 rtl/rand_range.sv | 139 +++++++++++++
 tb/tb_rand_range.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rand_range.sv
// ---------------------------------------------------------------------------
// rand_range
//
// Turns a stream of 32-bit PRNG words into uniformly distributed values in
// [0, limit) by mask-and-reject sampling. The upper WIDTH bits of each PRNG
// word are masked down to the smallest power-of-two span that covers the
// range. A candidate that falls outside the range is discarded and counted.
// Accepted values are queued in a 2-entry output FIFO.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   reset        : synchronous, active-high reset
//   rnd_data     : current 32-bit word from the upstream PRNG
//   rnd_next     : combinational; consumes rnd_data and advances the PRNG
//   enable       : permits draws from the PRNG
//   cfg_load     : single-cycle pulse that latches a new range from limit
//   limit        : exclusive upper bound; 0 selects the full 2^WIDTH range
//   out_valid    : an output word is available
//   out_ready    : the consumer accepts the output word this cycle
//   out_data     : head of the output FIFO
//   reject_count : saturating count of rejected candidates since reset or
//                  the last cfg_load
// ---------------------------------------------------------------------------
module rand_range #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      rnd_data,
   output logic             rnd_next,
   input  logic             enable,
   input  logic             cfg_load,
   input  logic [WIDTH-1:0] limit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [15:0]      reject_count
);

   typedef enum logic {
      RUN = 1'b0,
      CFG = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] limit_q;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_next;
   logic [WIDTH-1:0] limit_m1;
   logic [WIDTH-1:0] candidate;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic [1:0]       count;
   logic             pop;
   logic             draw;
   logic             accept;
   logic             push;
   logic             smear;

   // Mask covers every bit up to the MSB of (limit_q - 1). Built by smearing
   // set bits downward from the top; limit_q == 1 yields an all-zero mask.
   always_comb begin
      limit_m1  = limit_q - WIDTH'(1);
      mask_next = '0;
      smear     = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         smear                   = smear | limit_m1[WIDTH-1-i];
         mask_next[WIDTH-1-i]    = smear;
      end
      if (limit_q == '0) begin
         mask_next = '1;
      end
   end

   always_comb begin
      candidate = rnd_data[31 -: WIDTH] & mask_q;
      accept    = (limit_q == '0) || (candidate < limit_q);
      out_valid = (count != 2'd0);
      out_data  = head_q;
      pop       = out_valid & out_ready;
      // count never exceeds 2, so ~count[1] means "room for one more".
      draw      = ~reset & (state == RUN) & enable & ~cfg_load
                  & (~count[1] | pop);
      push      = draw & accept;
      rnd_next  = draw;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RUN;
         limit_q      <= '0;
         mask_q       <= '1;
         count        <= 2'd0;
         reject_count <= '0;
      end else if (cfg_load) begin
         // Flush wins over any pop this cycle; the mask follows in CFG.
         limit_q      <= limit;
         count        <= 2'd0;
         reject_count <= '0;
         state        <= CFG;
      end else begin
         if (state == CFG) begin
            mask_q <= mask_next;
            state  <= RUN;
         end

         // Head always holds the oldest word; tail is only meaningful at
         // count == 2.
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head_q <= candidate;
               end else begin
                  tail_q <= candidate;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head_q <= tail_q;
               count  <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head_q <= candidate;
               end else begin
                  head_q <= tail_q;
               end
               tail_q <= candidate;
            end
            default: ;
         endcase

         if (draw && !accept && (reject_count != 16'hFFFF)) begin
            reject_count <= reject_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_rand_range.sv
module tb_rand_range;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] rnd_data;
   logic        rnd_next;
   logic        enable;
   logic        cfg_load;
   logic [7:0]  limit;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [15:0] reject_count;

   rand_range #(.WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .rnd_data     (rnd_data),
      .rnd_next     (rnd_next),
      .enable       (enable),
      .cfg_load     (cfg_load),
      .limit        (limit),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .reject_count (reject_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of pending outputs, current range, reject count,
   // and number of cycles draws are still blocked after a range load.
   logic [7:0] m_q[$];
   int         m_limit = 0;
   int         m_rej   = 0;
   int         m_block = 0;

   logic       got_next, got_valid;
   logic [7:0] got_data;
   logic [15:0] got_rej;
   logic       exp_next, exp_valid;
   logic [7:0] exp_data;
   logic [15:0] exp_rej;

   // Uniform sampling rule: reduce the top byte modulo the smallest power of
   // two covering the range, then accept if it lies below the range.
   function automatic bit m_accept(input int lim, input int top, output int c);
      int p;
      if (lim == 0) begin
         c = top;
         return 1'b1;
      end
      p = 1;
      while (p < lim) p = p * 2;
      c = top % p;
      return (c < lim);
   endfunction

   // One clock: drive inputs, sample DUT and model at the falling edge,
   // advance the model at the rising edge.
   task automatic cycle(input logic r, input logic en, input logic cl,
                        input logic [7:0] lim, input logic rdy,
                        input logic [31:0] rd);
      int  c;
      bit  acc, pop;
      reset = r; enable = en; cfg_load = cl; limit = lim;
      out_ready = rdy; rnd_data = rd;
      pop       = (m_q.size() > 0) && rdy;
      exp_next  = !r && (m_block == 0) && en && !cl && (m_q.size() < 2 || pop);
      exp_valid = (m_q.size() != 0);
      exp_data  = exp_valid ? m_q[0] : 8'h00;
      exp_rej   = 16'(m_rej);
      @(negedge clk);
      got_next = rnd_next; got_valid = out_valid;
      got_data = out_data; got_rej = reject_count;
      @(posedge clk);
      if (r) begin
         m_q.delete(); m_limit = 0; m_rej = 0; m_block = 0;
      end else if (cl) begin
         m_q.delete(); m_limit = int'(lim); m_rej = 0; m_block = 1;
      end else begin
         if (m_block > 0) m_block--;
         if (pop) void'(m_q.pop_front());
         if (exp_next) begin
            acc = m_accept(m_limit, int'(rd[31:24]), c);
            if (acc) m_q.push_back(8'(c));
            else if (m_rej < 65535) m_rej++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      cycle(1, 1, 0, 8'h00, 1, 32'h1234_5678);
      cycle(1, 1, 0, 8'h00, 1, 32'h1234_5678);
      checks++; if (got_next !== 1'b0) begin errors++; $display("FAIL reset.rnd_next got %b exp 0", got_next); end
      checks++; if (got_valid !== 1'b0) begin errors++; $display("FAIL reset.out_valid got %b exp 0", got_valid); end
      checks++; if (got_rej !== 16'h0) begin errors++; $display("FAIL reset.reject_count got %h exp 0", got_rej); end
   endtask

   task automatic test_full_range();
      for (int i = 0; i < 6; i++) begin
         cycle(0, 1, 0, 8'h00, 1, 32'hA500_0000);
         checks++; if (got_next !== exp_next) begin errors++; $display("FAIL full_range.rnd_next cyc %0d got %b exp %b", i, got_next, exp_next); end
         checks++; if (got_valid !== exp_valid) begin errors++; $display("FAIL full_range.out_valid cyc %0d got %b exp %b", i, got_valid, exp_valid); end
         if (exp_valid) begin
            checks++; if (got_data !== exp_data) begin errors++; $display("FAIL full_range.out_data cyc %0d got %h exp %h", i, got_data, exp_data); end
         end
         checks++; if (got_rej !== exp_rej) begin errors++; $display("FAIL full_range.reject_count cyc %0d got %0d exp %0d", i, got_rej, exp_rej); end
      end
      checks++; if (got_data !== 8'hA5 || got_valid !== 1'b1) begin errors++; $display("FAIL full_range.steady got %h/%b exp a5/1", got_data, got_valid); end
   endtask

   task automatic test_limit10();
      logic [31:0] seq[9];
      seq = '{32'h0512_3456, 32'h0512_3456, 32'h0512_3456, 32'h0CAB_CDEF,
              32'h0C00_0001, 32'h0CFF_FFFF, 32'h1A00_0000, 32'h0300_0000,
              32'h0300_0000};
      cycle(0, 1, 1, 8'd10, 1, 32'h0500_0000);
      for (int i = 0; i < 11; i++) begin
         cycle(0, 1, 0, 8'd10, 1, i < 2 ? 32'h0500_0000 : seq[i-2]);
         checks++; if (got_next !== exp_next) begin errors++; $display("FAIL limit10.rnd_next cyc %0d got %b exp %b", i, got_next, exp_next); end
         checks++; if (got_valid !== exp_valid) begin errors++; $display("FAIL limit10.out_valid cyc %0d got %b exp %b", i, got_valid, exp_valid); end
         if (exp_valid) begin
            checks++; if (got_data !== exp_data) begin errors++; $display("FAIL limit10.out_data cyc %0d got %h exp %h", i, got_data, exp_data); end
         end
         checks++; if (got_rej !== exp_rej) begin errors++; $display("FAIL limit10.reject_count cyc %0d got %0d exp %0d", i, got_rej, exp_rej); end
      end
      checks++; if (got_rej !== 16'd4) begin errors++; $display("FAIL limit10.total_rejects got %0d exp 4", got_rej); end
   endtask

   task automatic test_limit1_and_0();
      for (int i = 0; i < 24; i++) begin
         logic cl;
         logic [7:0] lim;
         cl  = (i == 0) || (i == 12);
         lim = (i < 12) ? 8'd1 : 8'd0;
         cycle(0, 1, cl, lim, 1, $urandom);
         checks++; if (got_next !== exp_next) begin errors++; $display("FAIL lim1_0.rnd_next cyc %0d got %b exp %b", i, got_next, exp_next); end
         checks++; if (got_valid !== exp_valid) begin errors++; $display("FAIL lim1_0.out_valid cyc %0d got %b exp %b", i, got_valid, exp_valid); end
         if (exp_valid) begin
            checks++; if (got_data !== exp_data) begin errors++; $display("FAIL lim1_0.out_data cyc %0d got %h exp %h", i, got_data, exp_data); end
         end
         checks++; if (got_rej !== exp_rej) begin errors++; $display("FAIL lim1_0.reject_count cyc %0d got %0d exp %0d", i, got_rej, exp_rej); end
      end
   endtask

   task automatic test_backpressure();
      logic rdy;
      for (int i = 0; i < 10; i++) begin
         rdy = (i == 6) || (i >= 8);
         cycle(0, 1, 0, 8'd0, rdy, $urandom);
         checks++; if (got_next !== exp_next) begin errors++; $display("FAIL backpressure.rnd_next cyc %0d got %b exp %b", i, got_next, exp_next); end
         checks++; if (got_valid !== exp_valid) begin errors++; $display("FAIL backpressure.out_valid cyc %0d got %b exp %b", i, got_valid, exp_valid); end
         if (exp_valid) begin
            checks++; if (got_data !== exp_data) begin errors++; $display("FAIL backpressure.out_data cyc %0d got %h exp %h", i, got_data, exp_data); end
         end
         if (i == 5) begin
            checks++; if (got_next !== 1'b0) begin errors++; $display("FAIL backpressure.stalled got %b exp 0", got_next); end
         end
      end
   endtask

   task automatic test_cfg_flush();
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'd0, 0, $urandom);
      for (int i = 0; i < 6; i++) begin
         cycle(0, 1, i == 0, 8'd200, 1, $urandom);
         checks++; if (got_next !== exp_next) begin errors++; $display("FAIL cfg_flush.rnd_next cyc %0d got %b exp %b", i, got_next, exp_next); end
         checks++; if (got_valid !== exp_valid) begin errors++; $display("FAIL cfg_flush.out_valid cyc %0d got %b exp %b", i, got_valid, exp_valid); end
         if (exp_valid) begin
            checks++; if (got_data !== exp_data) begin errors++; $display("FAIL cfg_flush.out_data cyc %0d got %h exp %h", i, got_data, exp_data); end
         end
         checks++; if (got_rej !== exp_rej) begin errors++; $display("FAIL cfg_flush.reject_count cyc %0d got %0d exp %0d", i, got_rej, exp_rej); end
         if (i == 1) begin
            checks++; if (got_valid !== 1'b0 || got_next !== 1'b0) begin errors++; $display("FAIL cfg_flush.cfg_cycle got valid %b next %b exp 0 0", got_valid, got_next); end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         logic r, cl;
         logic [7:0] lim;
         r   = ($urandom_range(0, 299) == 0);
         cl  = ($urandom_range(0, 39) == 0);
         lim = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
         cycle(r, $urandom_range(0, 4) != 0, cl, lim, $urandom_range(0, 4) < 3, $urandom);
         checks++; if (got_next !== exp_next) begin errors++; $display("FAIL random.rnd_next cyc %0d got %b exp %b", i, got_next, exp_next); end
         checks++; if (got_valid !== exp_valid) begin errors++; $display("FAIL random.out_valid cyc %0d got %b exp %b", i, got_valid, exp_valid); end
         if (exp_valid) begin
            checks++; if (got_data !== exp_data) begin errors++; $display("FAIL random.out_data cyc %0d got %h exp %h", i, got_data, exp_data); end
         end
         checks++; if (got_rej !== exp_rej) begin errors++; $display("FAIL random.reject_count cyc %0d got %0d exp %0d", i, got_rej, exp_rej); end
      end
   endtask

   task automatic test_saturation();
      cycle(0, 1, 1, 8'd10, 1, 32'hFF00_0000);
      for (int i = 0; i < 65545; i++) begin
         cycle(0, 1, 0, 8'd10, 1, 32'hFF00_0000);
         checks++; if (got_rej !== exp_rej) begin errors++; $display("FAIL saturation.reject_count cyc %0d got %0d exp %0d", i, got_rej, exp_rej); end
      end
      checks++; if (got_rej !== 16'hFFFF) begin errors++; $display("FAIL saturation.held got %h exp ffff", got_rej); end
      cycle(1, 1, 0, 8'd10, 1, 32'hFF00_0000);
      cycle(0, 0, 0, 8'd10, 1, 32'hFF00_0000);
      checks++; if (got_rej !== 16'h0) begin errors++; $display("FAIL saturation.reset_rej got %h exp 0", got_rej); end
      checks++; if (got_valid !== 1'b0) begin errors++; $display("FAIL saturation.reset_valid got %b exp 0", got_valid); end
      cycle(0, 1, 0, 8'd0, 1, 32'h3C00_0000);
      cycle(0, 1, 0, 8'd0, 1, 32'h3C00_0000);
      checks++; if (got_valid !== 1'b1 || got_data !== 8'h3C) begin errors++; $display("FAIL saturation.full_range_after_reset got %b/%h exp 1/3c", got_valid, got_data); end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; limit = '0;
      out_ready = 1'b0; rnd_data = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_full_range();
      test_limit10();
      test_limit1_and_0();
      test_backpressure();
      test_cfg_flush();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
